// File: rtl/booth_pp_accum.sv
// rtl/booth_pp_accum.sv - Booth partial-product 4:2 reducer and final adder, 3-stage pipe
//
// Purpose: sums the four weighted partial products of an 8x8 radix-4 Booth
// generator into a 16-bit product (mod 2^16) through three elastic stages:
//   S1 input register (column-aligned rows), S2 4:2 carry-save compression,
//   S3 carry-propagate add into the registered product.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   pp0..pp3 hold a valid set
//   in_ready   out  1   set accepted when in_valid & in_ready
//   pp0        in  12   partial product, weight 2^0
//   pp1        in  11   partial product, weight 2^2
//   pp2        in  11   partial product, weight 2^4
//   pp3        in  10   partial product, weight 2^6
//   out_valid  out  1   product holds a valid result
//   out_ready  in   1   result taken when out_valid & out_ready
//   product    out 16   registered result
module booth_pp_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] pp0,
  input  logic [10:0] pp1,
  input  logic [10:0] pp2,
  input  logic [9:0]  pp3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  // Stage valid bits
  logic        v1_q;
  logic        v2_q;
  logic        out_valid_q;

  // S1: column-aligned rows
  logic [15:0] row0_q, row1_q, row2_q, row3_q;
  logic [15:0] row0_d, row1_d, row2_d, row3_d;

  // S2: carry-save pair
  logic [15:0] sum_q, carry_q;
  logic [15:0] sum_d, carry_d;

  // S3: resolved product
  logic [15:0] product_q;
  logic [15:0] product_d;

  // Stage load enables. Each stage loads when empty or when its successor
  // loads, so bubbles collapse and in_ready depends on out_ready only.
  logic        load1, load2, load3;

  assign load3    = !out_valid_q || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  // Alignment: zero fill below each LSB and above each MSB.
  assign row0_d = {4'b0000, pp0};
  assign row1_d = {3'b000, pp1, 2'b00};
  assign row2_d = {1'b0, pp2, 4'b0000};
  assign row3_d = {pp3, 6'b000000};

  // 4:2 compression as two rows of full adders. The first row reduces
  // rows 0..2 to a sum/carry pair; the second folds row 3 in. Carries are
  // shifted up one column and anything out of bit 15 is dropped, so only
  // the low 15 majority bits are ever formed.
  logic [15:0] fa1_sum;
  logic [14:0] fa1_maj;
  logic [15:0] fa1_carry;
  logic [14:0] fa2_maj;

  assign fa1_sum   = row0_q ^ row1_q ^ row2_q;
  assign fa1_maj   = (row0_q[14:0] & row1_q[14:0]) |
                     (row0_q[14:0] & row2_q[14:0]) |
                     (row1_q[14:0] & row2_q[14:0]);
  assign fa1_carry = {fa1_maj, 1'b0};

  assign sum_d     = fa1_sum ^ fa1_carry ^ row3_q;
  assign fa2_maj   = (fa1_sum[14:0] & fa1_carry[14:0]) |
                     (fa1_sum[14:0] & row3_q[14:0]) |
                     (fa1_carry[14:0] & row3_q[14:0]);
  assign carry_d   = {fa2_maj, 1'b0};

  assign product_d = sum_q + carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      row0_q      <= 16'h0000;
      row1_q      <= 16'h0000;
      row2_q      <= 16'h0000;
      row3_q      <= 16'h0000;
      sum_q       <= 16'h0000;
      carry_q     <= 16'h0000;
      product_q   <= 16'h0000;
    end else begin
      if (load1) begin
        v1_q <= in_valid;
        // Data only follows real transfers; a bubble leaves stale rows.
        if (in_valid) begin
          row0_q <= row0_d;
          row1_q <= row1_d;
          row2_q <= row2_d;
          row3_q <= row3_d;
        end
      end
      if (load2) begin
        v2_q    <= v1_q;
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
      if (load3) begin
        out_valid_q <= v2_q;
        product_q   <= product_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
